commit_trace_fifo: RTL

- Sits directly downstream of Simple_Single_CPU and consumes its architectural write-back events.
- Each cycle it captures any register-file write or data-memory write, together with the PC of the instruction that caused it.
- Captured events are buffered in a FIFO and drained over a valid/ready interface.
- It replaces per-cycle polling of REGISTER_BANK/memory arrays with an ordered commit trace that a checker or a UART dumper can consume at its own pace.

---
 rtl/commit_trace_fifo_if.sv | 39 +++
 rtl/commit_trace_fifo.sv | 101 ++++++++++
 2 files changed

// File: rtl/commit_trace_fifo_if.sv
// commit_trace_fifo_if: write-back capture inputs and trace drain handshake of commit_trace_fifo.
// slave is the FIFO's view; master is the CPU/consumer side.
interface commit_trace_fifo_if #(
    parameter int PTR_W  = 4,
    parameter int DROP_W = 16
);
    logic              cap_en_i;
    logic [31:0]       pc_i;
    logic              reg_we_i;
    logic [4:0]        reg_addr_i;
    logic [31:0]       reg_data_i;
    logic              mem_we_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       mem_data_i;
    logic              trace_ready_i;
    logic              trace_valid_o;
    logic              trace_kind_o;
    logic [31:0]       trace_pc_o;
    logic [31:0]       trace_addr_o;
    logic [31:0]       trace_data_o;
    logic [31:0]       trace_time_o;
    logic [PTR_W:0]    count_o;
    logic              overflow_o;
    logic [DROP_W-1:0] drop_cnt_o;

    modport slave (
        input  cap_en_i, pc_i, reg_we_i, reg_addr_i, reg_data_i,
               mem_we_i, mem_addr_i, mem_data_i, trace_ready_i,
        output trace_valid_o, trace_kind_o, trace_pc_o, trace_addr_o,
               trace_data_o, trace_time_o, count_o, overflow_o, drop_cnt_o
    );

    modport master (
        output cap_en_i, pc_i, reg_we_i, reg_addr_i, reg_data_i,
               mem_we_i, mem_addr_i, mem_data_i, trace_ready_i,
        input  trace_valid_o, trace_kind_o, trace_pc_o, trace_addr_o,
               trace_data_o, trace_time_o, count_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: ordered FIFO of register/memory write-back events with registered head outputs.
// Define TRACE_TIMESTAMP_EN to stamp each entry with a free-running 32-bit cycle count.
module commit_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4,
    parameter int DROP_W = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    commit_trace_fifo_if.slave t
);
    logic              kind_m [DEPTH];
    logic [31:0]       pc_m   [DEPTH];
    logic [31:0]       addr_m [DEPTH];
    logic [31:0]       data_m [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
    logic [PTR_W:0]    cnt_nxt;
    logic [DROP_W:0]   drop_sum;
    logic [1:0]        drops;
    logic              reg_ev, mem_ev, ev, full, pop, push, use_in, load;
    logic              in_kind;
    logic [31:0]       in_addr, in_data;

    always_comb begin
        reg_ev   = t.cap_en_i & t.reg_we_i & (t.reg_addr_i != 5'd0);
        mem_ev   = t.cap_en_i & t.mem_we_i;
        ev       = reg_ev | mem_ev;
        full     = t.count_o == (PTR_W+1)'(DEPTH);
        pop      = t.trace_valid_o & t.trace_ready_i;
        push     = ev & (~full | pop);
        // a rejected event plus a shadowed memory write can drop two in one cycle
        drops    = 2'(ev & ~push) + 2'(reg_ev & mem_ev);
        drop_sum = {1'b0, t.drop_cnt_o} + (DROP_W+1)'(drops);
        rd_nxt   = rd_ptr + PTR_W'(pop);
        cnt_nxt  = t.count_o + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        use_in   = t.count_o == (PTR_W+1)'(pop);
        load     = cnt_nxt != '0;
        in_kind  = ~reg_ev;
        in_addr  = reg_ev ? {27'd0, t.reg_addr_i} : t.mem_addr_i;
        in_data  = reg_ev ? t.reg_data_i : t.mem_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            kind_m[wr_ptr] <= in_kind;
            pc_m[wr_ptr]   <= t.pc_i;
            addr_m[wr_ptr] <= in_addr;
            data_m[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            t.count_o       <= '0;
            t.overflow_o    <= 1'b0;
            t.drop_cnt_o    <= '0;
            t.trace_valid_o <= 1'b0;
            t.trace_kind_o  <= 1'b0;
            t.trace_pc_o    <= '0;
            t.trace_addr_o  <= '0;
            t.trace_data_o  <= '0;
        end else begin
            wr_ptr          <= wr_ptr + PTR_W'(push);
            rd_ptr          <= rd_nxt;
            t.count_o       <= cnt_nxt;
            t.overflow_o    <= t.overflow_o | (drops != 2'd0);
            t.drop_cnt_o    <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            t.trace_valid_o <= load;
            // head comes from the incoming event when nothing older remains after this pop
            if (load) begin
                t.trace_kind_o <= use_in ? in_kind : kind_m[rd_nxt];
                t.trace_pc_o   <= use_in ? t.pc_i  : pc_m[rd_nxt];
                t.trace_addr_o <= use_in ? in_addr : addr_m[rd_nxt];
                t.trace_data_o <= use_in ? in_data : data_m[rd_nxt];
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] cyc;
    logic [31:0] time_m [DEPTH];

    always_ff @(posedge clk_i) begin
        if (push) time_m[wr_ptr] <= cyc;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cyc            <= '0;
            t.trace_time_o <= '0;
        end else begin
            cyc <= cyc + 32'd1;
            if (load) t.trace_time_o <= use_in ? cyc : time_m[rd_nxt];
        end
    end
`else
    assign t.trace_time_o = '0;
`endif
endmodule
